// File: rtl/clb_cfg_loader.sv
// Serial configuration loader for a clb6 logic block: hunts for a preamble,
// deserialises a 37-bit frame, checks odd parity and commits the word atomically.
module clb_cfg_loader #(
    parameter int unsigned CFG_W    = 37,
    parameter logic [3:0]  PREAMBLE = 4'b0010
) (
    input  logic             K,
    input  logic             RST,
    input  logic             DIN,
    input  logic             DVALID,
    output logic [CFG_W-1:0] CFG,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    output logic             LOADED
);

    localparam int unsigned CNT_W = 6;
    localparam int unsigned WIN_W = 4;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CFG_W - 1);
    localparam logic [WIN_W-1:0] WIN_CLEAR = '1;

    // CLB power-on defaults: mem, comboption, o2m*_0, o2m*_1, DQmux, floporlatch, mux2..6
    localparam logic [CFG_W-1:0] CFG_DEFAULT = CFG_W'({
        16'b0000_0001_0001_0110,
        2'b00,
        3'b000,
        3'b111,
        2'b00,
        1'b0,
        2'b10, 2'b10, 2'b10, 2'b00, 2'b00
    });

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [WIN_W-1:0]   window, window_nxt, window_shift;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [CFG_W-1:0]   shadow, shadow_nxt;
    logic [CFG_W-1:0]   cfg_nxt;
    logic               busy_nxt, done_nxt, err_nxt, loaded_nxt;

    assign window_shift = {window[WIN_W-2:0], DIN};

    // State and datapath registers
    always_ff @(posedge K) begin
        if (RST) begin
            state  <= IDLE;
            window <= WIN_CLEAR;
            cnt    <= '0;
            shadow <= '0;
            CFG    <= CFG_DEFAULT;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            ERR    <= 1'b0;
            LOADED <= 1'b0;
        end else begin
            state  <= state_nxt;
            window <= window_nxt;
            cnt    <= cnt_nxt;
            shadow <= shadow_nxt;
            CFG    <= cfg_nxt;
            BUSY   <= busy_nxt;
            DONE   <= done_nxt;
            ERR    <= err_nxt;
            LOADED <= loaded_nxt;
        end
    end

    // Next-state and output decode; nothing moves on edges without DVALID
    always_comb begin
        state_nxt  = state;
        window_nxt = window;
        cnt_nxt    = cnt;
        shadow_nxt = shadow;
        cfg_nxt    = CFG;
        loaded_nxt = LOADED;
        done_nxt   = 1'b0;
        err_nxt    = 1'b0;

        if (DVALID) begin
            case (state)
                IDLE: begin
                    window_nxt = window_shift;
                    if (window_shift == PREAMBLE) begin
                        state_nxt = SHIFT;
                        cnt_nxt   = '0;
                    end
                end
                SHIFT: begin
                    shadow_nxt = {shadow[CFG_W-2:0], DIN};
                    if (cnt == LAST_BIT) begin
                        state_nxt = PARITY;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                PARITY: begin
                    state_nxt  = IDLE;
                    // Cleared window keeps frame tail bits from aliasing as a preamble
                    window_nxt = WIN_CLEAR;
                    if ((^shadow) ^ DIN) begin
                        cfg_nxt    = shadow;
                        done_nxt   = 1'b1;
                        loaded_nxt = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                default: begin
                    state_nxt  = IDLE;
                    window_nxt = WIN_CLEAR;
                end
            endcase
        end

        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Self-checking bench for clb_cfg_loader: vector table, corner-case sequences
// and a randomized bit stream checked against a queue-based frame model.
module tb_clb_cfg_loader;

    localparam logic [36:0] CFG_DEF = 37'h00_22C0_E2A0;
    localparam logic [3:0]  PRE     = 4'b0010;

    logic        K = 1'b0;
    logic        RST = 1'b1;
    logic        DIN = 1'b0;
    logic        DVALID = 1'b0;
    logic [36:0] CFG;
    logic        BUSY, DONE, ERR, LOADED;

    clb_cfg_loader dut (
        .K      (K),
        .RST    (RST),
        .DIN    (DIN),
        .DVALID (DVALID),
        .CFG    (CFG),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .ERR    (ERR),
        .LOADED (LOADED)
    );

    always #5 K = ~K;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cyc = -1;
    int err_cyc  = -1;

    // Reference model: sampled bits kept in queues, frame judged by counting ones
    bit          m_hunt[$];
    bit          m_frame[$];
    bit          m_in_frame;
    logic [36:0] m_cfg;
    bit          m_loaded, m_done, m_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_hunt     = {1'b1, 1'b1, 1'b1, 1'b1};
        m_frame    = {};
        m_in_frame = 1'b0;
        m_cfg      = CFG_DEF;
        m_loaded   = 1'b0;
        m_done     = 1'b0;
        m_err      = 1'b0;
    endfunction

    function automatic void model_update(input logic rst, input logic din, input logic dv);
        int ones;
        m_done = 1'b0;
        m_err  = 1'b0;
        if (rst) begin
            model_reset();
        end else if (dv) begin
            if (!m_in_frame) begin
                m_hunt.push_back(din);
                if (m_hunt.size() > 4) void'(m_hunt.pop_front());
                if (m_hunt[0] == PRE[3] && m_hunt[1] == PRE[2] &&
                    m_hunt[2] == PRE[1] && m_hunt[3] == PRE[0]) begin
                    m_in_frame = 1'b1;
                    m_frame    = {};
                end
            end else begin
                m_frame.push_back(din);
                if (m_frame.size() == 38) begin
                    ones = 0;
                    foreach (m_frame[i]) ones += int'(m_frame[i]);
                    if (ones % 2 == 1) begin
                        for (int i = 0; i < 37; i++) m_cfg[36-i] = m_frame[i];
                        m_done   = 1'b1;
                        m_loaded = 1'b1;
                    end else begin
                        m_err = 1'b1;
                    end
                    m_in_frame = 1'b0;
                    m_hunt     = {1'b1, 1'b1, 1'b1, 1'b1};
                end
            end
        end
    endfunction

    // One clock: drive on the falling edge, compare 1 time unit after the rising edge
    task automatic cycle(input logic rst, input logic din, input logic dv);
        @(negedge K);
        RST    = rst;
        DIN    = din;
        DVALID = dv;
        @(posedge K);
        model_update(rst, din, dv);
        cyc++;
        #1;
        check("cfg",    64'(CFG),    64'(m_cfg));
        check("busy",   64'(BUSY),   64'(m_in_frame));
        check("done",   64'(DONE),   64'(m_done));
        check("err",    64'(ERR),    64'(m_err));
        check("loaded", 64'(LOADED), 64'(m_loaded));
        if (DONE) done_cyc = cyc;
        if (ERR)  err_cyc  = cyc;
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
    endtask

    // Preamble + 37 data bits (MSB first) + parity; idle cycles inserted between bits
    task automatic send_frame(input logic [36:0] data, input bit good, input int idle_each,
                              input int extra_at, input int extra_len, input int nbits,
                              output int start);
        bit bits[$];
        for (int i = 3; i >= 0; i--) bits.push_back(PRE[i]);
        for (int i = 36; i >= 0; i--) bits.push_back(data[i]);
        bits.push_back(good ? ~(^data) : ^data);
        start = cyc + 1;
        for (int i = 0; i < nbits; i++) begin
            cycle(1'b0, bits[i], 1'b1);
            if (i < nbits - 1) begin
                for (int g = 0; g < idle_each; g++) cycle(1'b0, 1'($urandom), 1'b0);
                if (i == extra_at)
                    for (int g = 0; g < extra_len; g++) cycle(1'b0, 1'($urandom), 1'b0);
            end
        end
    endtask

    typedef struct {
        string       name;
        logic [36:0] data;
        bit          good;
        bit          rst_first;
        int          idle_each;
        int          extra_at;
        int          extra_len;
        logic [36:0] exp_cfg;
        bit          exp_done;
        bit          exp_loaded;
        int          exp_cycles;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int          start, d1, d2;
        logic [36:0] d;

        vecs[0] = '{"good",      37'h1F_FFE0_0000, 1'b1, 1'b1, 0, 0,  0,  37'h1F_FFE0_0000, 1'b1, 1'b1, 42};
        vecs[1] = '{"badpar",    37'h1F_FFE0_0000, 1'b0, 1'b1, 0, 0,  0,  CFG_DEF,          1'b0, 1'b0, 42};
        vecs[2] = '{"gaps",      37'h1F_FFE0_0000, 1'b1, 1'b1, 1, 24, 10, 37'h1F_FFE0_0000, 1'b1, 1'b1, 93};
        vecs[3] = '{"a5a5",      37'h14_B4A0_0000, 1'b1, 1'b0, 0, 0,  0,  37'h14_B4A0_0000, 1'b1, 1'b1, 42};
        vecs[4] = '{"badkeep",   37'h00_1234_5678, 1'b0, 1'b0, 0, 0,  0,  37'h14_B4A0_0000, 1'b0, 1'b1, 42};

        model_reset();
        do_reset();
        check("rst_mem",    64'(CFG[36:21]), 64'h0116);
        check("rst_o2m1",   64'(CFG[15:13]), 64'b111);
        check("rst_mux",    64'(CFG[9:4]),   64'b101010);
        check("rst_zero",   64'({CFG[20:16], CFG[12:10], CFG[3:0]}), 64'h0);
        check("rst_flags",  64'({BUSY, DONE, ERR, LOADED}), 64'h0);

        foreach (vecs[v]) begin
            if (vecs[v].rst_first) do_reset();
            done_cyc = -1;
            err_cyc  = -1;
            send_frame(vecs[v].data, vecs[v].good, vecs[v].idle_each, vecs[v].extra_at,
                       vecs[v].extra_len, 42, start);
            check({vecs[v].name, "/cfg"},    64'(CFG),    64'(vecs[v].exp_cfg));
            check({vecs[v].name, "/loaded"}, 64'(LOADED), 64'(vecs[v].exp_loaded));
            check({vecs[v].name, "/done"},   64'(done_cyc >= 0), 64'(vecs[v].exp_done));
            check({vecs[v].name, "/err"},    64'(err_cyc >= 0),  64'(!vecs[v].exp_done));
            check({vecs[v].name, "/lat"},
                  64'((vecs[v].exp_done ? done_cyc : err_cyc) - start + 1),
                  64'(vecs[v].exp_cycles));
            cycle(1'b0, 1'b0, 1'b0);
            check({vecs[v].name, "/pulse"}, 64'({DONE, ERR}), 64'h0);
        end

        // Reset mid-frame after 20 data bits, then a fresh frame
        do_reset();
        send_frame(37'h0A_AAAA_AAAA, 1'b1, 0, 0, 0, 42, start);
        send_frame(37'h1F_FFE0_0000, 1'b1, 0, 0, 0, 24, start);
        cycle(1'b1, 1'b1, 1'b1);
        check("abort/cfg",    64'(CFG),    64'(CFG_DEF));
        check("abort/loaded", 64'(LOADED), 64'h0);
        check("abort/busy",   64'(BUSY),   64'h0);
        send_frame(37'h03_0F0F_1234, 1'b1, 0, 0, 0, 42, start);
        check("abort/new", 64'(CFG), 64'h03_0F0F_1234);

        // Back-to-back frames; first frame's data ends in the preamble pattern
        d = {16'hFFFF, 17'h0, 4'b0010};
        send_frame(d, 1'b1, 0, 0, 0, 42, start);
        d1 = done_cyc;
        send_frame({16'hA5A5, 21'h12345}, 1'b1, 0, 0, 0, 42, start);
        d2 = done_cyc;
        check("b2b/spacing", 64'(d2 - d1), 64'd42);
        check("b2b/mem",     64'(CFG[36:21]), 64'hA5A5);
        check("b2b/cfg",     64'(CFG), 64'({16'hA5A5, 21'h12345}));

        // Randomized stream: junk bits, occasional resets, random frames and gaps
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 19) == 0) cycle(1'b1, 1'($urandom), 1'($urandom));
            for (int j = 0; j < int'($urandom_range(0, 6)); j++)
                cycle(1'b0, 1'($urandom), 1'($urandom));
            d = 37'({$urandom(), $urandom()});
            send_frame(d, $urandom_range(0, 3) != 0, int'($urandom_range(0, 1)),
                       int'($urandom_range(0, 41)), int'($urandom_range(0, 3)), 42, start);
        end
        for (int j = 0; j < 4; j++) cycle(1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
